// File: rtl/module_alu_seq.sv
// Multi-cycle ALU with a start/done handshake: single-cycle arithmetic ops and an
// iterative sign-magnitude shift-add multiplier, all results and flags registered.
module module_alu_seq #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic             sinalImm,
    input  logic [IMM_W-1:0] Imm,
    input  logic [WIDTH-1:0] v1ULA,
    input  logic [WIDTH-1:0] v2ULA,
    output logic [WIDTH-1:0] valorGuardarULA,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             overflow
);
    localparam int ACC_W = WIDTH + IMM_W;
    localparam int CNT_W = $clog2(IMM_W + 1);
    localparam logic [ACC_W-1:0] MUL_LIM = ACC_W'(1) << (WIDTH - 1);

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL = 2'd2, S_DONE = 2'd3} state_t;

    state_t state_q, state_d;
    logic busy_q, busy_d, done_q, done_d;
    logic [2:0]       op_q, op_d;
    logic             sgn_q, sgn_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] v1_q, v1_d, v2_q, v2_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_s, mul_last_s, finish_s, new_ovf_s, mul_neg_s, mul_ovf_s;
    logic [WIDTH-1:0] immv_s, mag_s, mul_lo_s, mul_res_s, new_res_s;
    logic [WIDTH-1:0] add_s, addi_s, sub_s, subi_s;
    logic [ACC_W-1:0] partial_s, acc_sum_s;

    function automatic logic [WIDTH-1:0] imm_value(input logic sgn, input logic [IMM_W-1:0] mag);
        logic [WIDTH-1:0] ext;
        ext = {{(WIDTH-IMM_W){1'b0}}, mag};
        return sgn ? (-ext) : ext;
    endfunction

    function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] d);
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign accept_s   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign mul_last_s = (cnt_q == CNT_W'(IMM_W - 1));
    assign immv_s     = imm_value(sgn_q, imm_q);
    assign add_s      = v1_q + v2_q;
    assign addi_s     = v1_q + immv_s;
    assign sub_s      = v1_q - v2_q;
    assign subi_s     = v1_q - immv_s;
    // Multiplier works on |v1| (0x8000 maps to unsigned 32768) and reapplies the sign at the end.
    assign mag_s      = v1_q[WIDTH-1] ? (-v1_q) : v1_q;
    assign partial_s  = {{IMM_W{1'b0}}, mag_s} << cnt_q;
    assign acc_sum_s  = acc_q + (imm_q[cnt_q] ? partial_s : {ACC_W{1'b0}});
    assign mul_neg_s  = v1_q[WIDTH-1] ^ sgn_q;
    assign mul_lo_s   = acc_sum_s[WIDTH-1:0];
    assign mul_res_s  = mul_neg_s ? (-mul_lo_s) : mul_lo_s;
    assign mul_ovf_s  = mul_neg_s ? (acc_sum_s > MUL_LIM) : (acc_sum_s >= MUL_LIM);

    // State and handshake output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (opcode == OP_MUL) ? S_MUL : S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: state_d = S_DONE;
            S_MUL: begin
                if (mul_last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MUL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs follow the upcoming state so they come straight from flops
    always_comb begin
        busy_d = (state_d == S_EXEC) || (state_d == S_MUL);
        done_d = (state_d == S_DONE);
    end

    // Datapath next values: operand capture, multiplier iteration, result/flag update
    always_comb begin
        op_d      = op_q;
        sgn_d     = sgn_q;
        imm_d     = imm_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        finish_s  = 1'b0;
        new_res_s = res_q;
        new_ovf_s = 1'b0;
        case (state_q)
            S_EXEC: begin
                finish_s = 1'b1;
                case (op_q)
                    OP_LOAD:    new_res_s = immv_s;
                    OP_ADD:     begin new_res_s = add_s;  new_ovf_s = add_ovf(v1_q, v2_q, add_s);    end
                    OP_ADDI:    begin new_res_s = addi_s; new_ovf_s = add_ovf(v1_q, immv_s, addi_s); end
                    OP_SUB:     begin new_res_s = sub_s;  new_ovf_s = sub_ovf(v1_q, v2_q, sub_s);    end
                    OP_SUBI:    begin new_res_s = subi_s; new_ovf_s = sub_ovf(v1_q, immv_s, subi_s); end
                    OP_CLEAR:   new_res_s = {WIDTH{1'b0}};
                    OP_DISPLAY: new_res_s = res_q;
                    default:    new_res_s = res_q;
                endcase
            end
            S_MUL: begin
                acc_d = acc_sum_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (mul_last_s) begin
                    finish_s  = 1'b1;
                    new_res_s = mul_res_s;
                    new_ovf_s = mul_ovf_s;
                end else begin
                    finish_s  = 1'b0;
                end
            end
            default: finish_s = 1'b0;
        endcase
        if (finish_s) begin
            res_d  = new_res_s;
            zero_d = (new_res_s == {WIDTH{1'b0}});
            ovf_d  = new_ovf_s;
        end else begin
            res_d  = res_q;
        end
        if (accept_s) begin
            op_d  = opcode;
            sgn_d = sinalImm;
            imm_d = Imm;
            v1_d  = v1ULA;
            v2_d  = v2ULA;
            acc_d = {ACC_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
        end else begin
            op_d  = op_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= 3'b000;
            sgn_q  <= 1'b0;
            imm_q  <= {IMM_W{1'b0}};
            v1_q   <= {WIDTH{1'b0}};
            v2_q   <= {WIDTH{1'b0}};
            acc_q  <= {ACC_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            res_q  <= {WIDTH{1'b0}};
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            sgn_q  <= sgn_d;
            imm_q  <= imm_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign valorGuardarULA = res_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign zero            = zero_q;
    assign overflow        = ovf_q;

endmodule
